// File: rtl/operand_dispatcher_pkg.sv
// Shared types and default constants for the operand dispatcher.
package operand_dispatcher_pkg;

  // Dispatcher FSM states; encoding is fixed so that state dumps stay comparable.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam int unsigned N_DEF       = 8;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 32;

endpackage

// File: rtl/operand_dispatcher_pair_fifo.sv
// Operand-pair FIFO: W-bit entries, DEPTH deep (power of two), head always visible on dout.
module pair_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/operand_dispatcher.sv
// Operand dispatcher: queues operand pairs, launches them one at a time into an
// external serial adder, holds each result for the consumer and aborts stuck
// operations after TIMEOUT cycles.
module operand_dispatcher
  import operand_dispatcher_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         add_start,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  input  logic         add_done,
  input  logic [N-1:0] add_sum,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         err_timeout,
  output logic         busy
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2*N-1:0]  head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic            cnt_last;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign busy      = (state != IDLE) || !fifo_empty;
  assign cnt_last  = (cnt == CW'(TIMEOUT - 1));

  // The head entry stays in the FIFO while in flight, so pop happens only on WAIT exit.
  always_comb begin
    fifo_pop = 1'b0;
    if (state == WAIT) begin
      fifo_pop = add_done || cnt_last;
    end
  end

  pair_fifo #(
    .W     (2 * N),
    .DEPTH (DEPTH)
  ) u_pair_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({in_a, in_b}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Dispatch FSM with registered launch, result and error outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      add_start   <= 1'b0;
      add_a       <= '0;
      add_b       <= '0;
      out_valid   <= 1'b0;
      out_sum     <= '0;
      err_timeout <= 1'b0;
    end else begin
      add_start   <= 1'b0;
      err_timeout <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!fifo_empty && !out_valid) begin
            add_a     <= head[2*N-1:N];
            add_b     <= head[N-1:0];
            add_start <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Done is tested first so a completion on the last cycle still wins.
          if (add_done) begin
            out_sum   <= add_sum;
            out_valid <= 1'b1;
            state     <= IDLE;
          end else if (cnt_last) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_dispatcher.sv
// Self-checking bench for operand_dispatcher with a behavioural serial-adder model.
module tb_operand_dispatcher;

  localparam int unsigned N       = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         add_start;
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_done;
  logic [N-1:0] add_sum;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         err_timeout;
  logic         busy;

  always #5 clk = ~clk;

  operand_dispatcher #(
    .N       (N),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .add_start   (add_start),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_done    (add_done),
    .add_sum     (add_sum),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .err_timeout (err_timeout),
    .busy        (busy)
  );

  int tests = 0;
  int fails = 0;
  int err_count = 0;

  logic [N-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Adder model: done pulses 'lat' cycles after add_start is seen; skipped launches never finish.
  int           lat = 9;
  int           skip_launches = 0;
  int           cd = 0;
  logic [N-1:0] sa;
  logic [N-1:0] sb;

  initial begin
    add_done = 1'b0;
    add_sum  = '0;
    sa       = '0;
    sb       = '0;
    forever begin
      @(posedge clk);
      #1;
      add_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          add_done = 1'b1;
          add_sum  = sa + sb;
        end
      end
      if (add_start) begin
        if (skip_launches > 0) begin
          skip_launches--;
        end else begin
          sa = add_a;
          sb = add_b;
          cd = lat;
        end
      end
    end
  end

  // Scoreboard: each accepted result is compared against the oldest expected sum.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got 0x%0h, expected no result", out_sum);
        end else begin
          check("result", 32'(out_sum), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Counts err_timeout high cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (err_timeout) err_count++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b, input bit track,
                      input logic [N-1:0] exp);
    int unsigned g = 0;
    while (!in_ready && g < 200) begin
      tick();
      g++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL push_wait: in_ready=0, expected 1 within 200 cycles");
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    if (track) exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int unsigned g = 0;
    while (!add_start && g < 100) begin
      tick();
      g++;
    end
    check(name, 32'(add_start), 32'd1);
  endtask

  task automatic wait_drain(input int unsigned bound);
    int unsigned g = 0;
    while (exp_q.size() > 0 && g < bound) begin
      tick();
      g++;
    end
    tick();
    check("drain", exp_q.size(), 32'd0);
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    int           lat;
    logic [N-1:0] sum;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int unsigned n;
    int          s;
    int          ov;

    vecs[0] = '{8'h35, 8'h4A, 9,  8'h7F};
    vecs[1] = '{8'hFF, 8'h01, 9,  8'h00};
    vecs[2] = '{8'h80, 8'h80, 1,  8'h00};
    vecs[3] = '{8'hAA, 8'h55, 3,  8'hFF};
    vecs[4] = '{8'hC8, 8'h64, 5,  8'h2C};
    vecs[5] = '{8'h00, 8'h00, 2,  8'h00};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_add_start", 32'(add_start), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Single operations from the vector table
    out_ready = 1'b1;
    err_count = 0;
    for (int i = 0; i < 6; i++) begin
      lat = vecs[i].lat;
      push(vecs[i].a, vecs[i].b, 1'b1, vecs[i].sum);
      wait_start("vec_launch");
      check("vec_add_a", 32'(add_a), 32'(vecs[i].a));
      check("vec_add_b", 32'(add_b), 32'(vecs[i].b));
      tick();
      check("vec_start_pulse", 32'(add_start), 32'd0);
      check("vec_add_a_hold", 32'(add_a), 32'(vecs[i].a));
      wait_drain(lat + 20);
    end
    check("vec_no_err", err_count, 32'd0);

    // Back-pressure: first result held, FIFO fills, results leave in push order
    out_ready = 1'b0;
    lat = 9;
    push(8'h10, 8'h01, 1'b1, 8'h11);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check("bp_first_valid", 32'(out_valid), 32'd1);
    push(8'h20, 8'h02, 1'b1, 8'h22);
    push(8'h30, 8'h03, 1'b1, 8'h33);
    push(8'h40, 8'h04, 1'b1, 8'h44);
    push(8'h50, 8'h05, 1'b1, 8'h55);
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    s = 0;
    for (int k = 0; k < 20; k++) begin
      if (add_start) s++;
      tick();
    end
    check("bp_no_launch", s, 32'd0);
    check("bp_out_valid_hold", 32'(out_valid), 32'd1);
    check("bp_out_sum_hold", 32'(out_sum), 32'h11);
    out_ready = 1'b1;
    wait_drain(300);

    // Timeout: first pair never completes, second pair follows
    err_count = 0;
    lat = 9;
    skip_launches = 1;
    push(8'h11, 8'h22, 1'b0, 8'h00);
    push(8'h33, 8'h44, 1'b1, 8'h77);
    wait_start("to_launch");
    n = 0;
    while (!err_timeout && n < TIMEOUT + 10) begin
      tick();
      n++;
    end
    // err_timeout is registered, so it appears TIMEOUT cycles after the LAUNCH cycle ends.
    check("to_latency", n, TIMEOUT + 1);
    check("to_err_high", 32'(err_timeout), 32'd1);
    check("to_no_result", 32'(out_valid), 32'd0);
    tick();
    check("to_err_pulse", 32'(err_timeout), 32'd0);
    wait_start("to_next_launch");
    check("to_next_add_a", 32'(add_a), 32'h33);
    check("to_next_add_b", 32'(add_b), 32'h44);
    wait_drain(50);
    check("to_err_count", err_count, 32'd1);

    // Done coincides with the last WAIT cycle: done wins
    err_count = 0;
    lat = TIMEOUT;
    push(8'h5A, 8'h26, 1'b1, 8'h80);
    wait_drain(TIMEOUT + 20);
    check("co_no_err", err_count, 32'd0);

    // Reset in the middle of WAIT with two entries queued
    lat = 9;
    err_count = 0;
    push(8'h01, 8'h02, 1'b0, 8'h00);
    wait_start("rw_launch");
    push(8'h03, 8'h04, 1'b0, 8'h00);
    push(8'h05, 8'h06, 1'b0, 8'h00);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_in_ready", 32'(in_ready), 32'd1);
    check("rw_out_valid", 32'(out_valid), 32'd0);
    check("rw_add_start", 32'(add_start), 32'd0);
    check("rw_add_a", 32'(add_a), 32'd0);
    tick();
    #3;
    reset = 1'b1;
    tick();
    s  = 0;
    ov = 0;
    for (int k = 0; k < 20; k++) begin
      if (add_start) s++;
      if (out_valid) ov++;
      tick();
    end
    check("rw_no_launch", s, 32'd0);
    check("rw_no_result", ov, 32'd0);
    check("rw_no_err", err_count, 32'd0);
    check("rw_busy_after", 32'(busy), 32'd0);
    check("rw_adder_idle", cd, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/operand_dispatcher.md
OPERAND_DISPATCHER -- requirements
Module: operand_dispatcher

Interface
REQ-001 Parameter N, default 8, operand and sum width in bits.
REQ-002 Parameter DEPTH, default 4, operand-pair FIFO depth; power of two, at least 2.
REQ-003 Parameter TIMEOUT, default 32, maximum cycles in WAIT before abort; at least N+4.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operand pair offered.
REQ-007 in_ready  output  1  FIFO can accept a pair.
REQ-008 in_a, in_b  input  N each  operands A and B.
REQ-009 add_start  output  1  one-cycle launch pulse to the serial adder.
REQ-010 add_a, add_b  output  N each  operands to the adder, registered.
REQ-011 add_done  input  1  adder completion flag.
REQ-012 add_sum  input  N  adder result, valid while add_done=1.
REQ-013 out_valid  output  1  result held for the consumer.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 out_sum  output  N  result data.
REQ-016 err_timeout  output  1  one-cycle pulse when an operation aborts on timeout.
REQ-017 busy  output  1  high when FSM state is not IDLE or the FIFO is non-empty.

Function
REQ-018 FIFO: push when in_valid and in_ready are both high; in_ready = !full.
REQ-019 FIFO pop occurs only on WAIT exit (done or timeout); push and pop in the same cycle leave count unchanged.
REQ-020 FIFO pointers wrap modulo DEPTH; count is clog2(DEPTH)+1 bits wide.
REQ-021 FSM states are IDLE, LAUNCH and WAIT.
REQ-022 IDLE -> LAUNCH when the FIFO is non-empty and out_valid=0; add_a/add_b load from the FIFO head on this transition.
REQ-023 LAUNCH: add_start=1 for exactly this cycle, the timeout counter clears to 0, then -> WAIT unconditionally.
REQ-024 add_a/add_b hold stable from LAUNCH through WAIT exit.
REQ-025 WAIT with add_done=1: capture add_sum into out_sum, set out_valid, pop the FIFO, -> IDLE.
REQ-026 WAIT with add_done=0: the counter increments; at counter == TIMEOUT-1: err_timeout=1 for one cycle, pop (entry discarded), out_valid unchanged, -> IDLE.
REQ-027 If add_done and the timeout coincide, done wins: result captured, no err_timeout.
REQ-028 add_done is ignored in IDLE and LAUNCH.
REQ-029 out_valid clears on the cycle after out_valid and out_ready are both high.
REQ-030 out_sum holds while out_valid=1 and out_ready=0.
REQ-031 Sum is N bits; carry out of the MSB is discarded (modulo 2^N).
REQ-032 Minimum launch-to-launch spacing is 3 cycles plus adder latency.

Reset
REQ-033 reset low: immediately FSM=IDLE, FIFO empty, counter=0.
REQ-034 Under reset, outputs are: add_start=0, add_a=add_b=0, out_valid=0, out_sum=0, err_timeout=0, in_ready=1, busy=0.
REQ-035 Reset asserted mid-WAIT abandons the in-flight operation: no result and no err_timeout is produced.
REQ-036 A late add_done after reset release is ignored per REQ-028.

Structure
REQ-037 A shared package holds the FSM state enum (2-bit encoding IDLE=0, LAUNCH=1, WAIT=2) and the default constants N, DEPTH and TIMEOUT.
REQ-038 One sub-module, pair_fifo (2N-bit wide, DEPTH deep, push/pop/full/empty, async active-low reset), is instantiated once; all FSM logic stays in operand_dispatcher.

Verification
REQ-039 Single op: push A=0x35, B=0x4A; model adder asserts done with 0x7F after 9 cycles -> add_start pulses once with add_a=0x35, add_b=0x4A; out_valid=1, out_sum=0x7F.
REQ-040 Wrap: A=0xFF, B=0x01 -> out_sum=0x00, no error flag.
REQ-041 Fill/back-pressure: out_ready=0, push 5 pairs -> first pair launches and completes, in_ready drops after 4 further pushes, no second launch until the first result is accepted; results emerge in push order.
REQ-042 Timeout: adder never asserts done -> err_timeout pulses exactly TIMEOUT cycles after LAUNCH, entry dropped, next pair launches.
REQ-043 Coincidence: done asserted on cycle TIMEOUT-1 of WAIT -> result captured, err_timeout stays 0.
REQ-044 Reset during WAIT with 2 entries queued -> FIFO empty, out_valid=0, busy=0; a done pulse after release produces no output.
